// File: rtl/uart_pkg.sv
// Shared UART definitions.
// Contents:
//   uart_rx_state_t   - receiver FSM state encoding
//   UART_DATA_BITS    - default payload width of a frame
//   calc_clks_per_bit - clock cycles per bit from clock frequency and baud rate,
//                       rounded to nearest; shared with the transmitter
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } uart_rx_state_t;

    localparam int UART_DATA_BITS = 32'sd8;

    function automatic int calc_clks_per_bit(input int clk_hz, input int baud);
        return (clk_hz + (baud / 32'sd2)) / baud;
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// Both flops reset to 1 so an idle-high line looks idle straight out of reset.
// Ports:
//   clk - sampling clock
//   rst - asynchronous active-low reset
//   d   - asynchronous input
//   q   - synchronized output (2 cycles of latency)
module uart_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic sync_r;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_r <= 1'b1;
            sync_r <= 1'b1;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with mid-bit sampling driven by a clock-cycle baud counter.
// Ports:
//   clk       - system clock, all logic on posedge
//   rst       - asynchronous active-low reset
//   rx        - asynchronous serial input, idle high
//   data      - last correctly framed byte
//   valid     - one-cycle pulse: data was just updated
//   frame_err - one-cycle pulse: stop bit sampled low
//   busy      - high while the FSM is outside IDLE
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 32'sd868,
    parameter int DATA_BITS    = UART_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int HALF = CLKS_PER_BIT / 32'sd2;
    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int IW   = (DATA_BITS > 32'sd1) ? $clog2(DATA_BITS) : 32'sd1;

    if (CLKS_PER_BIT < 32'sd4) begin : g_bad_clks_per_bit
        $error("uart_receiver: CLKS_PER_BIT must be >= 4");
    end

    logic                 rx_s;
    uart_rx_state_t       state_r, state_nx_s;
    logic [CW-1:0]        cnt_r, cnt_nx_s;
    logic [IW-1:0]        idx_r, idx_nx_s;
    logic [DATA_BITS-1:0] shift_r, shift_nx_s;
    logic [DATA_BITS-1:0] data_r, data_nx_s;
    logic                 valid_r, valid_nx_s;
    logic                 ferr_r, ferr_nx_s;

    uart_sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    // Next-state, counter and strobe decode.
    // The counter holds cycles elapsed since the last sample point (or since
    // leaving IDLE), so the start sample lands HALF cycles after t0 and every
    // later sample CLKS_PER_BIT cycles after the previous one.
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r + CW'(1);
        idx_nx_s   = idx_r;
        shift_nx_s = shift_r;
        data_nx_s  = data_r;
        valid_nx_s = 1'b0;
        ferr_nx_s  = 1'b0;
        case (state_r)
            IDLE: begin
                cnt_nx_s = '0;
                if (!rx_s) begin
                    state_nx_s = START;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            START: begin
                if (cnt_r == CW'(HALF - 32'sd1)) begin
                    cnt_nx_s = '0;
                    if (rx_s) begin
                        // Line went back high before mid-start: a glitch.
                        state_nx_s = IDLE;
                    end else begin
                        state_nx_s = DATA;
                        idx_nx_s   = '0;
                    end
                end else begin
                    state_nx_s = START;
                end
            end
            DATA: begin
                if (cnt_r == CW'(CLKS_PER_BIT - 32'sd1)) begin
                    cnt_nx_s            = '0;
                    shift_nx_s[idx_r]   = rx_s;
                    if (idx_r == IW'(DATA_BITS - 32'sd1)) begin
                        state_nx_s = STOP;
                    end else begin
                        idx_nx_s = idx_r + IW'(1);
                    end
                end else begin
                    state_nx_s = DATA;
                end
            end
            STOP: begin
                if (cnt_r == CW'(CLKS_PER_BIT - 32'sd1)) begin
                    // Leaving at mid-stop lets a zero-gap next start be caught.
                    cnt_nx_s = '0;
                    if (rx_s) begin
                        data_nx_s  = shift_r;
                        valid_nx_s = 1'b1;
                        state_nx_s = IDLE;
                    end else begin
                        ferr_nx_s  = 1'b1;
                        state_nx_s = BREAK;
                    end
                end else begin
                    state_nx_s = STOP;
                end
            end
            BREAK: begin
                // A held-low line must not be decoded as a stream of 0x00.
                cnt_nx_s = '0;
                if (rx_s) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = BREAK;
                end
            end
            default: begin
                state_nx_s = IDLE;
                cnt_nx_s   = '0;
            end
        endcase
    end

    // State, datapath and registered output strobes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            idx_r   <= '0;
            shift_r <= '0;
            data_r  <= '0;
            valid_r <= 1'b0;
            ferr_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            cnt_r   <= cnt_nx_s;
            idx_r   <= idx_nx_s;
            shift_r <= shift_nx_s;
            data_r  <= data_nx_s;
            valid_r <= valid_nx_s;
            ferr_r  <= ferr_nx_s;
        end
    end

    assign data      = data_r;
    assign valid     = valid_r;
    assign frame_err = ferr_r;
    assign busy      = (state_r != IDLE);

endmodule
